regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Arbitrates the register file's single write port between the pipeline write-back stage and a long-latency unit (multiply/divide, cache-miss load) that returns results out of pipeline order. Keeps a busy-bit scoreboard of destinations with outstanding long-latency results and drives the decode-stage stall for RAW/WAW hazards on them. Buffers long-latency results in a small FIFO until the write port is free. Sits between WB, the long-latency unit, decode, and the register file write port (`write_reg`, `write_value`; `write_reg == 0` means no write).

## Interface
Parameters:
- `BUF_DEPTH`, 2: long-latency result FIFO depth (power of two, ≥ 2).
- `STARVE_LIMIT`, 4: consecutive cycles a non-empty FIFO may be blocked by WB before decode is forced to stall.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wb_en`  in  1  WB stage writes this cycle.
- `wb_reg`  in  5  WB destination.
- `wb_data`  in  32  WB value.
- `llu_valid`  in  1  long-latency result offered.
- `llu_reg`  in  5  its destination.
- `llu_data`  in  32  its value.
- `llu_ready`  out  1  FIFO can accept; transfer when `llu_valid & llu_ready`.
- `issue_valid`  in  1  decode issues a long-latency op this cycle.
- `issue_reg`  in  5  its destination.
- `dec_src1`, `dec_src2`, `dec_dst`  in  5 each  registers of the instruction in decode.
- `dec_stall`  out  1  hold decode and insert a bubble.
- `write_reg`  out  5  to register file; 0 = no write.
- `write_value`  out  32  to register file.

## Operation
- Scoreboard: `busy[31:0]`; `busy[0]` is constant 0.
  - Set `busy[issue_reg]` on `issue_valid & ~dec_stall & issue_reg != 0`.
  - Clear `busy[r]` when the FIFO head for `r` is written to the register file.
  - Set and clear of the same register in one cycle: set wins.
- Transfers with `llu_reg == 0` are accepted and discarded (not enqueued).
- Long-latency results always enter the FIFO; there is no combinational bypass.
- Port selection (combinational):
  - WB wins when `wb_en & wb_reg != 0`.
  - Otherwise the FIFO head is written and popped if the FIFO is non-empty.
  - Otherwise `write_reg = 0` and `write_value = 0`.
- `llu_ready = ~full | pop`; a push and a pop in the same cycle are allowed when full.
- Starvation counter: increments each cycle the FIFO is non-empty and WB wins; resets to 0 on a pop or when the FIFO is empty; saturates at `STARVE_LIMIT`.
- `dec_stall` is asserted when any of the following holds:
  - `busy[dec_src1]`, `busy[dec_src2]`, or `busy[dec_dst]` for a nonzero register (RAW/WAW);
  - the starvation counter equals `STARVE_LIMIT`, held until the FIFO is empty;
  - `issue_valid` is high and the pending-result count (busy bits set) equals 31.
- Checkers (simulation-only assertions):
  - issue to a register already busy;
  - an LLU result for a register that is not busy;
  - `wb_en` to a register that is busy.

## Timing
- Reset (synchronous, while `rst` is high):
  - `busy` is cleared, the FIFO is emptied, and the starvation counter is set to 0.
  - Outputs are forced: `write_reg = 0`, `write_value = 0`, `llu_ready = 0`, `dec_stall = 1`.
  - Any in-flight FIFO contents are dropped.
- The first cycle after `rst` falls: `llu_ready = 1`, `dec_stall` reflects the hazard logic.
- Latencies:
  - Long-latency result to register-file write: minimum 1 cycle (accepted at edge N, written in cycle N+1 if WB is idle).
  - Scoreboard set: visible to `dec_stall` from the cycle after issue.
  - Scoreboard clear: the busy bit drops at the edge ending the write cycle. A dependent instruction is released the cycle after the write, which relies on the register file's write-then-read behaviour within the cycle.
- `dec_stall`, `llu_ready`, `write_reg` and `write_value` are combinational from the current state and current inputs; they contain no combinational path from `llu_valid` to `llu_ready`.

## Test plan
- Reset, then issue to r5, then LLU result r5=0xDEADBEEF one cycle later with WB idle -> `write_reg=5`, `write_value=0xDEADBEEF` on the next cycle, `busy[5]` cleared, the `dec_src1=5` stall drops the cycle after.
- Issue to r8; decode `dec_src2=8` -> `dec_stall=1` until r8 is written. Decode with `dec_src1=0` -> no stall.
- Two LLU results (r3, r4) with WB writing r9..r12 on four consecutive cycles -> FIFO full, `llu_ready=0`. Counter reaches 4 -> `dec_stall=1`. First idle WB cycle writes r3, the next writes r4, and the stall clears after the FIFO empties.
- Full FIFO plus WB idle plus a new LLU result in the same cycle -> pop and push both occur, `llu_ready=1`, order preserved (r3, r4, r6).
- Issue to r7 with a simultaneous FIFO write of an earlier r7 result -> `busy[7]` remains 1.
- `rst` asserted with 2 entries queued and `busy[3]`, `busy[4]` set -> after reset the FIFO is empty, `busy=0`, `write_reg=0`, and no stale write occurs.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between WB and a long-latency unit, and keeps a busy-bit
// scoreboard that stalls decode on hazards against outstanding long-latency results.
module regfile_write_arbiter #(
  parameter int unsigned BUF_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        llu_valid,
  input  logic [4:0]  llu_reg,
  input  logic [31:0] llu_data,
  output logic        llu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  input  logic [4:0]  dec_src1,
  input  logic [4:0]  dec_src2,
  input  logic [4:0]  dec_dst,
  output logic        dec_stall,
  output logic [4:0]  write_reg,
  output logic [31:0] write_value
);

  localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [31:0]   busy_q, busy_d;
  logic [4:0]    fifo_reg_q  [BUF_DEPTH];
  logic [31:0]   fifo_data_q [BUF_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          hold_q, hold_d;

  logic        empty, full, wb_win, pop, push, issue_ok;
  logic        hazard, starve_stall, pending_full;
  logic [5:0]  pending;
  logic [4:0]  head_reg;
  logic [31:0] head_data;

  assign head_reg  = fifo_reg_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW + 1)'(BUF_DEPTH));
  assign wb_win    = wb_en && (wb_reg != 5'd0);
  assign pop       = !rst && !empty && !wb_win;
  // Depends only on state and WB, never on llu_valid.
  assign llu_ready = !rst && (!full || pop);
  assign push      = llu_valid && llu_ready && (llu_reg != 5'd0);

  always_comb begin
    pending = '0;
    for (int i = 1; i < 32; i++) begin
      pending = pending + 6'(busy_q[i]);
    end
  end

  assign pending_full = (pending == 6'd31);
  assign hazard = ((dec_src1 != 5'd0) && busy_q[dec_src1]) ||
                  ((dec_src2 != 5'd0) && busy_q[dec_src2]) ||
                  ((dec_dst  != 5'd0) && busy_q[dec_dst]);
  // Once the counter saturates, the stall is held until the FIFO drains completely.
  assign starve_stall = (starve_q == SW'(STARVE_LIMIT)) || hold_q;
  assign dec_stall    = rst || hazard || starve_stall || (issue_valid && pending_full);
  assign issue_ok     = issue_valid && !dec_stall && (issue_reg != 5'd0);

  always_comb begin
    write_reg   = 5'd0;
    write_value = 32'd0;
    if (!rst) begin
      if (wb_win) begin
        write_reg   = wb_reg;
        write_value = wb_data;
      end else if (!empty) begin
        write_reg   = head_reg;
        write_value = head_data;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head_reg] = 1'b0;
    if (issue_ok) busy_d[issue_reg] = 1'b1;
    busy_d[0] = 1'b0;

    count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);

    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (wb_win && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end

    hold_d = starve_stall && (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      hold_q   <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg_q[wr_ptr_q]  <= llu_reg;
      fifo_data_q[wr_ptr_q] <= llu_data;
    end
  end

  // An issue is legal against a busy register only if that register's result is written now.
  a_issue_busy: assert property (@(posedge clk) disable iff (rst)
    issue_ok |-> (!busy_q[issue_reg] || (pop && (head_reg == issue_reg))));
  a_llu_not_busy: assert property (@(posedge clk) disable iff (rst)
    push |-> busy_q[llu_reg]);
  a_wb_busy: assert property (@(posedge clk) disable iff (rst)
    wb_win |-> !busy_q[wb_reg]);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: expected register-file writes go into a queue, a negedge monitor pops and
// compares each write the DUT presents; stall/ready are compared directly mid-cycle.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        llu_valid;
  logic [4:0]  llu_reg;
  logic [31:0] llu_data;
  logic        llu_ready;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [4:0]  dec_src1, dec_src2, dec_dst;
  logic        dec_stall;
  logic [4:0]  write_reg;
  logic [31:0] write_value;

  int n_vec  = 0;
  int n_miss = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  regfile_write_arbiter #(.BUF_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .llu_valid(llu_valid), .llu_reg(llu_reg), .llu_data(llu_data), .llu_ready(llu_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .dec_src1(dec_src1), .dec_src2(dec_src2), .dec_dst(dec_dst), .dec_stall(dec_stall),
    .write_reg(write_reg), .write_value(write_value)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    wb_en = 0; wb_reg = 0; wb_data = 0;
    llu_valid = 0; llu_reg = 0; llu_data = 0;
    issue_valid = 0; issue_reg = 0;
    dec_src1 = 0; dec_src2 = 0; dec_dst = 0;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic issue(input logic [4:0] r);
    cyc(); idle(); issue_valid = 1; issue_reg = r;
  endtask

  task automatic llu(input logic [4:0] r, input logic [31:0] d);
    llu_valid = 1; llu_reg = r; llu_data = d;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1; wb_reg = r; wb_data = d;
  endtask

  always @(negedge clk) begin
    if (write_reg != 5'd0) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_write: got r%0d=%h expected none", write_reg, write_value);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_reg", 32'(write_reg), 32'(mon_e[36:32]));
        chk("write_value", write_value, mon_e[31:0]);
      end
    end
  end

  initial begin
    // Reset, with activity on every input that must be ignored.
    rst = 1; idle();
    wb(5'd1, 32'h1111_1111); llu(5'd2, 32'h2222); issue_valid = 1; issue_reg = 5'd2;
    cyc(); cyc(); settle();
    chk("rst_write_reg", 32'(write_reg), 0);
    chk("rst_llu_ready", 32'(llu_ready), 0);
    chk("rst_dec_stall", 32'(dec_stall), 1);

    // Test 1: issue r5, result one cycle later, write, release.
    cyc(); idle(); rst = 0; issue_valid = 1; issue_reg = 5'd5; settle();
    chk("post_rst_ready", 32'(llu_ready), 1);
    chk("post_rst_stall", 32'(dec_stall), 0);
    cyc(); idle(); llu(5'd5, 32'hDEADBEEF); dec_src1 = 5'd5; expect_wr(5'd5, 32'hDEADBEEF);
    settle();
    chk("t1_raw_stall", 32'(dec_stall), 1);
    chk("t1_ready", 32'(llu_ready), 1);
    cyc(); idle(); dec_src1 = 5'd5; settle();
    chk("t1_write_cycle_stall", 32'(dec_stall), 1);
    cyc(); idle(); dec_src1 = 5'd5; settle();
    chk("t1_released", 32'(dec_stall), 0);

    // Test 2: RAW via src2, WAW via dst, register 0 never stalls.
    issue(5'd8);
    cyc(); idle(); dec_src2 = 5'd8; settle();
    chk("t2_src2_stall", 32'(dec_stall), 1);
    cyc(); idle(); dec_dst = 5'd8; settle();
    chk("t2_waw_stall", 32'(dec_stall), 1);
    cyc(); idle(); settle();
    chk("t2_src_zero", 32'(dec_stall), 0);
    cyc(); idle(); llu(5'd8, 32'h8888_0008); dec_src2 = 5'd8; expect_wr(5'd8, 32'h8888_0008);
    settle();
    chk("t2_stall_pending", 32'(dec_stall), 1);
    cyc(); idle(); dec_src2 = 5'd8; settle();
    chk("t2_stall_write", 32'(dec_stall), 1);
    cyc(); idle(); dec_src2 = 5'd8; settle();
    chk("t2_released", 32'(dec_stall), 0);

    // Test 3: WB hogs the port, FIFO fills, starvation stall until drained.
    issue(5'd3);
    issue(5'd4);
    expect_wr(5'd9, 32'h9999); expect_wr(5'd10, 32'hAAAA);
    expect_wr(5'd11, 32'hBBBB); expect_wr(5'd12, 32'hCCCC);
    expect_wr(5'd3, 32'h3333); expect_wr(5'd4, 32'h4444);
    cyc(); idle(); llu(5'd3, 32'h3333); settle();
    chk("t3_ready_c0", 32'(llu_ready), 1);
    cyc(); idle(); llu(5'd4, 32'h4444); wb(5'd9, 32'h9999); settle();
    chk("t3_ready_c1", 32'(llu_ready), 1);
    cyc(); idle(); wb(5'd10, 32'hAAAA); settle();
    chk("t3_full_not_ready", 32'(llu_ready), 0);
    cyc(); idle(); wb(5'd11, 32'hBBBB); settle();
    chk("t3_cnt2_no_stall", 32'(dec_stall), 0);
    cyc(); idle(); wb(5'd12, 32'hCCCC); settle();
    chk("t3_cnt3_no_stall", 32'(dec_stall), 0);
    cyc(); idle(); settle();
    chk("t3_starve_stall", 32'(dec_stall), 1);
    chk("t3_ready_on_pop", 32'(llu_ready), 1);
    cyc(); idle(); settle();
    chk("t3_stall_held", 32'(dec_stall), 1);
    cyc(); idle(); settle();
    chk("t3_stall_clear", 32'(dec_stall), 0);

    // Test 4: full FIFO, WB idle, new result: simultaneous pop and push, order kept.
    issue(5'd3);
    issue(5'd4);
    issue(5'd6);
    expect_wr(5'd13, 32'h1313); expect_wr(5'd14, 32'h1414);
    expect_wr(5'd3, 32'h3003); expect_wr(5'd4, 32'h4004); expect_wr(5'd6, 32'h6006);
    cyc(); idle(); llu(5'd3, 32'h3003); wb(5'd13, 32'h1313);
    cyc(); idle(); llu(5'd4, 32'h4004); wb(5'd14, 32'h1414);
    cyc(); idle(); llu(5'd6, 32'h6006); settle();
    chk("t4_full_pop_push_ready", 32'(llu_ready), 1);
    cyc(); idle();
    cyc(); idle();
    cyc(); idle(); settle();
    chk("t4_no_stall", 32'(dec_stall), 0);

    // Test 5: re-issue r7 in the cycle its earlier result is written; set wins.
    issue(5'd7);
    cyc(); idle(); llu(5'd7, 32'h7777); expect_wr(5'd7, 32'h7777);
    cyc(); idle(); issue_valid = 1; issue_reg = 5'd7; settle();
    chk("t5_issue_accepted", 32'(dec_stall), 0);
    cyc(); idle(); dec_src1 = 5'd7; settle();
    chk("t5_set_wins", 32'(dec_stall), 1);
    cyc(); idle(); llu(5'd7, 32'h7070); dec_src1 = 5'd7; expect_wr(5'd7, 32'h7070);
    cyc(); idle(); dec_src1 = 5'd7;
    cyc(); idle(); dec_src1 = 5'd7; settle();
    chk("t5_released", 32'(dec_stall), 0);

    // Test 6: reset with two queued entries drops them and clears the scoreboard.
    issue(5'd3);
    issue(5'd4);
    expect_wr(5'd20, 32'h2020); expect_wr(5'd21, 32'h2121);
    cyc(); idle(); llu(5'd3, 32'h3ABC); wb(5'd20, 32'h2020);
    cyc(); idle(); llu(5'd4, 32'h4ABC); wb(5'd21, 32'h2121);
    cyc(); idle(); rst = 1; settle();
    chk("t6_rst_write_reg", 32'(write_reg), 0);
    chk("t6_rst_ready", 32'(llu_ready), 0);
    chk("t6_rst_stall", 32'(dec_stall), 1);
    cyc(); idle();
    cyc(); idle(); rst = 0; dec_src1 = 5'd3; dec_src2 = 5'd4; settle();
    chk("t6_busy_cleared", 32'(dec_stall), 0);
    chk("t6_ready", 32'(llu_ready), 1);
    chk("t6_no_stale_write", 32'(write_reg), 0);

    // Test 7: result for r0 is accepted and discarded.
    cyc(); idle(); llu(5'd0, 32'h0BAD); settle();
    chk("t7_r0_ready", 32'(llu_ready), 1);
    cyc(); idle(); settle();
    chk("t7_r0_no_write", 32'(write_reg), 0);

    repeat (3) cyc();
    chk("exp_queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
